psr_icc_unit: RTL

PSR_ICC_UNIT -- requirements
Module: psr_icc_unit

---
 rtl/psr_icc_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/psr_icc_unit.sv
// SPARC-style PSR holder: integer condition codes, window pointer,
// trap entry sequencing and Bicc branch condition evaluation.
module psr_icc_unit #(
    parameter int NWINDOWS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_n,
    input  logic                alu_z,
    input  logic                alu_v,
    input  logic                alu_c,
    input  logic                icc_we,
    input  logic                psr_we,
    input  logic [31:0]         psr_wdata,
    input  logic [1:0]          cwp_op,
    input  logic [NWINDOWS-1:0] wim,
    input  logic                trap_req,
    input  logic [7:0]          trap_type,
    input  logic                br_valid,
    input  logic [3:0]          br_cond,
    output logic [31:0]         psr,
    output logic                carry_out,
    output logic                br_done,
    output logic                br_taken,
    output logic                trap_taken,
    output logic [7:0]          tt,
    output logic                error_mode
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_TRAP,
        ST_ERROR
    } state_t;

    localparam logic [1:0] CWP_NONE    = 2'b00;
    localparam logic [1:0] CWP_SAVE    = 2'b01;
    localparam logic [1:0] CWP_RESTORE = 2'b10;
    localparam logic [1:0] CWP_RETT    = 2'b11;

    localparam logic [5:0] NW6    = 6'(NWINDOWS);
    localparam logic [4:0] NW_MAX = 5'(NWINDOWS - 1);

    state_t      state;
    logic        f_n, f_z, f_v, f_c;
    logic        f_s, f_ps, f_et;
    logic [4:0]  cwp;
    logic [4:0]  cwp_dec;
    logic [4:0]  cwp_inc;
    logic [4:0]  wr_cwp;
    logic [31:0] wim_ext;
    logic        cond_base;
    logic        cond_met;

    // Reduce a 5-bit window number into 0..NWINDOWS-1.
    function automatic logic [4:0] mod_nw(input logic [4:0] v);
        logic [5:0] r;
        r = {1'b0, v};
        for (int i = 0; i < 32; i++) begin
            if (r >= NW6) r = r - NW6;
        end
        return r[4:0];
    endfunction

    assign cwp_dec = (cwp == 5'd0) ? NW_MAX : cwp - 5'd1;
    assign cwp_inc = (cwp == NW_MAX) ? 5'd0 : cwp + 5'd1;
    assign wr_cwp  = mod_nw(psr_wdata[4:0]);
    assign wim_ext = 32'(wim);

    // Bicc decode: codes 9-F invert 1-7, 8 inverts "never".
    always_comb begin
        cond_base = 1'b0;
        case (br_cond[2:0])
            3'd0: cond_base = 1'b0;
            3'd1: cond_base = f_z;
            3'd2: cond_base = f_z | (f_n ^ f_v);
            3'd3: cond_base = f_n ^ f_v;
            3'd4: cond_base = f_c | f_z;
            3'd5: cond_base = f_c;
            3'd6: cond_base = f_n;
            3'd7: cond_base = f_v;
            default: cond_base = 1'b0;
        endcase
        cond_met = cond_base ^ br_cond[3];
    end

    // PSR state, trap sequencing and branch result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            f_n      <= 1'b0;
            f_z      <= 1'b0;
            f_v      <= 1'b0;
            f_c      <= 1'b0;
            f_s      <= 1'b1;
            f_ps     <= 1'b0;
            f_et     <= 1'b0;
            cwp      <= 5'd0;
            tt       <= 8'h00;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            br_done <= br_valid && (state != ST_ERROR);
            if (br_valid && (state != ST_ERROR)) begin
                br_taken <= cond_met;
            end
            unique case (state)
                ST_RUN: begin
                    if (trap_req) begin
                        tt    <= trap_type;
                        state <= ST_TRAP;
                    end else if (psr_we) begin
                        f_n  <= psr_wdata[23];
                        f_z  <= psr_wdata[22];
                        f_v  <= psr_wdata[21];
                        f_c  <= psr_wdata[20];
                        f_s  <= psr_wdata[7];
                        f_ps <= psr_wdata[6];
                        f_et <= psr_wdata[5];
                        cwp  <= wr_cwp;
                    end else if (cwp_op != CWP_NONE) begin
                        unique case (cwp_op)
                            CWP_SAVE: begin
                                if (wim_ext[cwp_dec]) begin
                                    tt    <= 8'h05;
                                    state <= ST_TRAP;
                                end else begin
                                    cwp <= cwp_dec;
                                end
                            end
                            CWP_RESTORE: begin
                                if (wim_ext[cwp_inc]) begin
                                    tt    <= 8'h06;
                                    state <= ST_TRAP;
                                end else begin
                                    cwp <= cwp_inc;
                                end
                            end
                            CWP_RETT: begin
                                if (f_et) begin
                                    tt    <= 8'h02;
                                    state <= ST_TRAP;
                                end else if (wim_ext[cwp_inc]) begin
                                    tt    <= 8'h06;
                                    state <= ST_TRAP;
                                end else begin
                                    cwp  <= cwp_inc;
                                    f_et <= 1'b1;
                                    f_s  <= f_ps;
                                end
                            end
                            default: ;
                        endcase
                    end else if (icc_we) begin
                        f_n <= alu_n;
                        f_z <= alu_z;
                        f_v <= alu_v;
                        f_c <= alu_c;
                    end
                end
                ST_TRAP: begin
                    if (f_et) begin
                        f_et  <= 1'b0;
                        f_ps  <= f_s;
                        f_s   <= 1'b1;
                        cwp   <= cwp_dec;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_ERROR;
                    end
                end
                ST_ERROR: ;
                default: state <= ST_RUN;
            endcase
        end
    end

    assign psr = {8'h00, f_n, f_z, f_v, f_c, 12'h000,
                  f_s, f_ps, f_et, cwp};
    assign carry_out  = f_c;
    assign trap_taken = (state == ST_TRAP) && f_et;
    assign error_mode = (state == ST_ERROR);

endmodule
